// File: rtl/data_memory_block.sv
// Data-memory pipeline stage: single-port 2**ADDR_W x 16 RAM with a registered stage result.
// Define DATA_MEMORY_CLEAR_EN to add the post-reset memory-clear sequence (INIT state, busy).
module data_memory_block #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ans_ex,
    input  logic [15:0] st_data_ex,
    input  logic        mem_en_ex,
    input  logic        mem_rw_ex,
    input  logic        stall,
    output logic [15:0] ans_dm,
    output logic        busy
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              ans_ld;
    logic [DATA_W-1:0] ans_nxt;

    // Upper result bits are ignored, so addresses wrap modulo DEPTH.
    assign addr = ans_ex[ADDR_W-1:0];

`ifdef DATA_MEMORY_CLEAR_EN
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= INIT;
        else        state <= state_nxt;
    end

    // INIT leaves after the last word has been cleared.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (&clr_cnt) state_nxt = RUN;
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)             clr_cnt <= '0;
        else if (state == INIT) clr_cnt <= clr_cnt + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy <= 1'b1;
        else        busy <= (state_nxt == INIT);
    end
`else
    assign busy = 1'b0;
`endif

    // Memory port and stage-result selection; writes are gated off while reset is low.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = st_data_ex;
        ans_ld    = 1'b0;
        ans_nxt   = ans_ex;
`ifdef DATA_MEMORY_CLEAR_EN
        if (state == INIT) begin
            mem_we    = reset;
            mem_waddr = clr_cnt;
            mem_wdata = '0;
        end else
`endif
        if (!stall) begin
            ans_ld = 1'b1;
            if (mem_en_ex && mem_rw_ex) mem_we  = reset;
            else if (mem_en_ex)         ans_nxt = mem[addr];
        end
    end

    // The array itself is never reset; only the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      ans_dm <= '0;
        else if (ans_ld) ans_dm <= ans_nxt;
    end

endmodule

// File: doc/data_memory_block.md
DATA_MEMORY_BLOCK -- requirements
Module: data_memory_block

Interface
REQ-001 Parameter ADDR_W, default 8, data-memory address width; DEPTH = 2**ADDR_W words of 16 bits.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk).
REQ-004 ans_ex  input  16  execute-stage result; bits [ADDR_W-1:0] form the memory address.
REQ-005 st_data_ex  input  16  store data from the execute stage.
REQ-006 mem_en_ex  input  1  memory access request this cycle.
REQ-007 mem_rw_ex  input  1  access type: 1=store, 0=load; ignored when mem_en_ex=0.
REQ-008 stall  input  1  freeze request from hazard control.
REQ-009 ans_dm  output  16  registered stage result, consumed by the write-back stage.
REQ-010 busy  output  1  high while the memory-clear sequence runs; upstream must hold the pipeline.

Function
REQ-011 The block SHALL hold a DEPTH x 16 single-port data memory, written and read only on posedge clk.
REQ-012 Address SHALL be ans_ex[ADDR_W-1:0]; upper bits ignored (wrap modulo DEPTH).
REQ-013 FSM states SHALL be INIT and RUN; busy=1 exactly in INIT.
REQ-014 INIT: each cycle write 0 to mem[clr_cnt] and increment clr_cnt; after writing DEPTH-1 the next state is RUN (INIT lasts exactly DEPTH cycles).
REQ-015 In INIT, mem_en_ex, mem_rw_ex, st_data_ex and stall SHALL be ignored and ans_dm SHALL hold 0.
REQ-016 RUN, stall=0, mem_en_ex=1, mem_rw_ex=1: mem[addr] <= st_data_ex; ans_dm <= ans_ex.
REQ-017 RUN, stall=0, mem_en_ex=1, mem_rw_ex=0: ans_dm <= mem[addr] (one-cycle latency: value visible after the sampling edge).
REQ-018 RUN, stall=0, mem_en_ex=0: ans_dm <= ans_ex; memory unchanged.
REQ-019 RUN, stall=1: ans_dm holds, memory SHALL NOT be written, regardless of mem_en_ex.
REQ-020 Store at edge N followed by load of same address at edge N+1 SHALL return the stored value.
REQ-021 Stall asserted/deasserted on consecutive cycles SHALL lose or duplicate no access: each unstalled edge performs exactly one operation.

Reset
REQ-022 On reset=0: ans_dm=0, clr_cnt=0, state=INIT (RUN when the clear feature is compiled out), asynchronously.
REQ-023 Memory array SHALL NOT be asynchronously reset; it is cleared only by INIT.
REQ-024 Reset asserted mid-INIT SHALL restart the clear sequence from address 0 on release.
REQ-025 Reset asserted mid-RUN SHALL abandon any in-flight access; no write occurs on the edge where reset=0.

Configuration
REQ-026 Macro DATA_MEMORY_CLEAR_EN defined: INIT state and clr_cnt present, behaviour per REQ-013..015.
REQ-027 Macro DATA_MEMORY_CLEAR_EN undefined: no INIT state or clr_cnt; block enters RUN directly from reset, busy tied 0, memory contents undefined until written.

Verification
REQ-028 Reset, release, DATA_MEMORY_CLEAR_EN defined, ADDR_W=8 -> busy=1 for exactly 256 cycles then 0; load of addresses 0x00, 0x7F, 0xFF returns 0x0000.
REQ-029 Store st_data_ex=0xBEEF to ans_ex=0x0012, then load ans_ex=0x0012 next cycle -> ans_dm=0xBEEF one edge after the load; ans_dm=0x0012 after the store edge.
REQ-030 Store 0x1234 to ans_ex=0x0105 (ADDR_W=8) then load ans_ex=0x0005 -> ans_dm=0x1234 (address wrap).
REQ-031 Store 0xAAAA to 0x20 with stall=1 for 3 cycles then stall=0 -> ans_dm frozen during stall, single write on release, later load of 0x20 returns 0xAAAA.
REQ-032 ALU pass-through: mem_en_ex=0, ans_ex=0x5A5A -> ans_dm=0x5A5A after one edge, memory unchanged.
REQ-033 Assert reset at INIT cycle 100 -> ans_dm=0 immediately, busy=1 again for full 256 cycles after release.
